// File: rtl/frame_tx_if.sv
// Packet handshake between a PE/router output stage and the transmit framer.
interface frame_tx_if #(
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned DATA_BYTES = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DEST_WIDTH-1:0]   in_dest;
    logic [8*DATA_BYTES-1:0] in_data;

    modport master (output in_valid, in_dest, in_data, input in_ready);
    modport slave  (input in_valid, in_dest, in_data, output in_ready);
endinterface

// File: rtl/frame_tx.sv
// Transmit framer: one packet per frame, flag-delimited and byte-stuffed,
// emitted one byte per clock followed by a single pad byte.
module frame_tx #(
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic [7:0]  FLAG       = 8'h7E,
    parameter logic [7:0]  ESC        = 8'h7D,
    parameter logic [7:0]  ESC_XOR    = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_tx_if.slave            in_if,
    output logic [7:0]           tx_byte,
    output logic                 tx_active,
    output logic [CNT_WIDTH-1:0] frames_sent
);
    localparam int unsigned SH_W  = DEST_WIDTH + 8*DATA_BYTES;
    localparam int unsigned IDX_W = $clog2(DATA_BYTES + 1);

    typedef enum logic [2:0] {IDLE, DEST, DATA, ESC2, END, PAD} state_e;

    state_e               state_q, state_d;
    logic [SH_W-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           pend_q, pend_d;
    logic [7:0]           tx_q, tx_d;
    logic                 act_q, act_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 accept, adv;
    logic [7:0]           cur;

    assign accept      = in_if.in_valid && ready_q;
    assign in_if.in_ready = ready_q;
    assign tx_byte     = tx_q;
    assign tx_active   = act_q;
    assign frames_sent = cnt_q;

    // idx_q counts header+payload bytes already emitted: 0 is dest, DATA_BYTES is the last payload byte
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        tx_d    = 8'h00;
        act_d   = 1'b0;
        adv     = 1'b0;
        cur     = shift_q[SH_W-1 -: 8];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = {in_if.in_dest, in_if.in_data};
                    idx_d   = '0;
                    tx_d    = FLAG;
                    act_d   = 1'b1;
                    state_d = DEST;
                end
            end
            DEST, DATA: begin
                act_d = 1'b1;
                if (cur == FLAG || cur == ESC) begin
                    tx_d    = ESC;
                    pend_d  = cur;
                    state_d = ESC2;
                end else begin
                    tx_d = cur;
                    adv  = 1'b1;
                end
            end
            ESC2: begin
                act_d = 1'b1;
                tx_d  = pend_q ^ ESC_XOR;
                adv   = 1'b1;
            end
            END: begin
                act_d   = 1'b1;
                tx_d    = FLAG;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = PAD;
            end
            PAD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (adv) begin
            shift_d = {shift_q[SH_W-9:0], 8'h00};
            if (idx_q == IDX_W'(DATA_BYTES)) begin
                state_d = END;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = DATA;
            end
        end

        // ready is high exactly while the link shows the pad byte or idles
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            pend_q  <= 8'h00;
            tx_q    <= 8'h00;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: expected byte streams are written out by hand.
module tb_frame_tx;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic [CW-1:0] frames_sent;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] eb[$];
    logic       ea[$];
    logic       er[$];

    frame_tx_if #(.DEST_WIDTH(8), .DATA_BYTES(4)) bus ();

    frame_tx #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (bus),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Offer a packet, wait (bounded) for ready, and release valid after the accepting edge.
    task automatic offer(input logic [7:0] d, input logic [31:0] p);
        int waited;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_dest  = d;
        bus.in_data  = p;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("offer_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Compare tx_byte/tx_active/in_ready against the queued expectations, one per cycle.
    task automatic expect_stream(input string tag, input int drop_at, input logic [7:0] d2,
                                 input logic [31:0] p2);
        for (int i = 0; i < eb.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s_byte%0d", tag, i), 32'(tx_byte), 32'(eb[i]));
            check($sformatf("%s_act%0d", tag, i), 32'(tx_active), 32'(ea[i]));
            check($sformatf("%s_rdy%0d", tag, i), 32'(bus.in_ready), 32'(er[i]));
            if (i == drop_at) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
        end
        if (d2 != 8'h00 || p2 != 32'h0) begin
            bus.in_dest = d2;
            bus.in_data = p2;
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_dest  = 8'h00;
        bus.in_data  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_byte", 32'(tx_byte), 32'h00);
        check("idle_act", 32'(tx_active), 32'd0);
        check("idle_rdy", 32'(bus.in_ready), 32'd1);
        check("idle_cnt", 32'(frames_sent), 32'd0);

        // plain frame, no stuffing
        offer(8'h11, 32'h1111_1111);
        eb = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h7E, 8'h00};
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expect_stream("plain", -1, 8'h00, 32'h0);
        check("plain_cnt", 32'(frames_sent), 32'd1);

        // stuffed dest and first payload byte
        offer(8'h7E, 32'h7D44_0000);
        eb = '{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h44, 8'h00, 8'h00, 8'h7E, 8'h00};
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expect_stream("esc", -1, 8'h00, 32'h0);
        check("esc_cnt", 32'(frames_sent), 32'd2);

        // escape on the final payload byte must still reach the end flag
        offer(8'h01, 32'h0000_007D);
        eb = '{8'h7E, 8'h01, 8'h00, 8'h00, 8'h00, 8'h7D, 8'h5D, 8'h7E, 8'h00};
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expect_stream("esclast", -1, 8'h00, 32'h0);
        check("esclast_cnt", 32'(frames_sent), 32'd3);

        // back-to-back with valid held across both accepts
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_dest  = 8'h00;
        bus.in_data  = 32'h2222_2222;
        check("b2b_rdy0", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_dest = 8'h10;
        bus.in_data = 32'h3333_3333;
        eb = '{8'h7E, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22, 8'h7E, 8'h00,
               8'h7E, 8'h10, 8'h33, 8'h33, 8'h33, 8'h33, 8'h7E, 8'h00};
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expect_stream("b2b", 7, 8'h00, 32'h0);
        check("b2b_cnt", 32'(frames_sent), 32'd5);

        // asynchronous reset during the third payload byte
        offer(8'h55, 32'h0102_0304);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("rst_pre_byte", 32'(tx_byte), 32'h03);
        #2 rst = 1'b0;
        #1;
        check("rst_byte", 32'(tx_byte), 32'h00);
        check("rst_act", 32'(tx_active), 32'd0);
        check("rst_cnt", 32'(frames_sent), 32'd0);
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        offer(8'h20, 32'hDEAD_BEEF);
        eb = '{8'h7E, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h7E, 8'h00};
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expect_stream("post", -1, 8'h00, 32'h0);
        check("post_cnt", 32'(frames_sent), 32'd1);

        // counter wrap with a 4-bit frame counter
        for (int k = 0; k < 14; k++) begin
            offer(8'(k + 1), {4{8'(k + 1)}});
            repeat (8) @(negedge clk);
        end
        check("wrap_pre_cnt", 32'(frames_sent), 32'd15);
        offer(8'h42, 32'h0A0B_0C0D);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 5) check("wrap_last_data_cnt", 32'(frames_sent), 32'd15);
            if (i == 6) begin
                check("wrap_end_byte", 32'(tx_byte), 32'h7E);
                check("wrap_end_cnt", 32'(frames_sent), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
